// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator; VGA_TIMING_FRAME_CNT_EN adds frame_cnt
module vga_timing_gen #(
  parameter int H_AV  = 640,
  parameter int H_FP  = 16,
  parameter int H_SP  = 96,
  parameter int H_BP  = 48,
  parameter int V_AV  = 480,
  parameter int V_FP  = 11,
  parameter int V_SP  = 2,
  parameter int V_BP  = 32,
  parameter bit H_POL = 1'b0,
  parameter bit V_POL = 1'b0,
  parameter int CW    = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pix_en,
  output logic          hSync,
  output logic          vSync,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          valid,
  output logic          line_start,
`ifdef VGA_TIMING_FRAME_CNT_EN
  output logic [7:0]    frame_cnt,
`endif
  output logic          frame_start
);
  localparam logic [CW-1:0] H_LAST = CW'(H_AV + H_FP + H_SP + H_BP - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_AV + V_FP + V_SP + V_BP - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_AV);
  localparam logic [CW-1:0] V_ACT  = CW'(V_AV);
  localparam logic [CW-1:0] HS_ON  = CW'(H_AV + H_FP);
  localparam logic [CW-1:0] HS_OFF = CW'(H_AV + H_FP + H_SP);
  localparam logic [CW-1:0] VS_ON  = CW'(V_AV + V_FP);
  localparam logic [CW-1:0] VS_OFF = CW'(V_AV + V_FP + V_SP);
  logic [CW-1:0] nx, ny;
  logic          h_wrap, f_wrap;
  // next raster position; sync/valid are decoded from it so they line up with x/y
  always_comb begin
    h_wrap = x == H_LAST;
    f_wrap = h_wrap && y == V_LAST;
    nx     = h_wrap ? '0 : x + 1'b1;
    ny     = h_wrap ? (y == V_LAST ? '0 : y + 1'b1) : y;
  end
  // position, decoded outputs and one-clk start pulses; reset parks on the last blanking pixel
  always_ff @(posedge clk) begin
    if (reset) begin
      x           <= H_LAST;
      y           <= V_LAST;
      valid       <= 1'b0;
      hSync       <= ~H_POL;
      vSync       <= ~V_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= pix_en && h_wrap;
      frame_start <= pix_en && f_wrap;
      if (pix_en) begin
        x     <= nx;
        y     <= ny;
        valid <= nx < H_ACT && ny < V_ACT;
        hSync <= (nx >= HS_ON && nx < HS_OFF) ? H_POL : ~H_POL;
        vSync <= (ny >= VS_ON && ny < VS_OFF) ? V_POL : ~V_POL;
      end
    end
  end
`ifdef VGA_TIMING_FRAME_CNT_EN
  // frame counter steps with each frame_start pulse
  always_ff @(posedge clk) begin
    if (reset) frame_cnt <= '0;
    else if (pix_en && f_wrap) frame_cnt <= frame_cnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen on a reduced raster
module tb_vga_timing_gen;
  localparam int HA = 8, HF = 2, HS = 3, HB = 2, HT = HA + HF + HS + HB;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1, VT = VA + VF + VS + VB;
  localparam bit HP = 1'b0, VP = 1'b1;
  localparam int CW = 5;
  typedef struct {int x, y, hs, vs, va, ls, fs, fc;} exp_t;
  logic clk = 1'b0, reset = 1'b1, pix_en = 1'b0;
  logic hSync, vSync, valid, line_start, frame_start;
  logic [CW-1:0] x, y;
  logic [7:0] frame_cnt;
  exp_t q[$];
  int tests = 0, fails = 0;
  int mx = 0, my = 0, mfc = 0;
  vga_timing_gen #(
    .H_AV(HA), .H_FP(HF), .H_SP(HS), .H_BP(HB),
    .V_AV(VA), .V_FP(VF), .V_SP(VS), .V_BP(VB),
    .H_POL(HP), .V_POL(VP), .CW(CW)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .hSync(hSync), .vSync(vSync),
    .x(x), .y(y), .valid(valid), .line_start(line_start),
`ifdef VGA_TIMING_FRAME_CNT_EN
    .frame_cnt(frame_cnt),
`endif
    .frame_start(frame_start)
  );
`ifndef VGA_TIMING_FRAME_CNT_EN
  assign frame_cnt = 8'd0;
`endif
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s at (%0d,%0d): got %0d expected %0d", tag, mx, my, got, want);
    end
  endtask
  task automatic step(input logic r, input logic pe);
    exp_t e, g;
    int ls, fs;
    @(negedge clk);
    reset = r;
    pix_en = pe;
    ls = 0;
    fs = 0;
    if (r) begin
      mx = HT - 1;
      my = VT - 1;
      mfc = 0;
    end else if (pe) begin
      ls = mx == HT - 1;
      fs = ls && my == VT - 1;
      if (ls) begin
        mx = 0;
        my = my == VT - 1 ? 0 : my + 1;
      end else mx = mx + 1;
      if (fs) mfc = (mfc + 1) % 256;
    end
    e.x = mx;
    e.y = my;
    e.va = mx < HA && my < VA;
    e.hs = (mx >= HA + HF && mx < HA + HF + HS) ? int'(HP) : int'(!HP);
    e.vs = (my >= VA + VF && my < VA + VF + VS) ? int'(VP) : int'(!VP);
    e.ls = ls;
    e.fs = fs;
    e.fc = mfc;
`ifndef VGA_TIMING_FRAME_CNT_EN
    e.fc = 0;
`endif
    q.push_back(e);
    @(posedge clk);
    #1;
    g = q.pop_front();
    check("x", int'(x), g.x);
    check("y", int'(y), g.y);
    check("valid", int'(valid), g.va);
    check("hSync", int'(hSync), g.hs);
    check("vSync", int'(vSync), g.vs);
    check("line_start", int'(line_start), g.ls);
    check("frame_start", int'(frame_start), g.fs);
`ifdef VGA_TIMING_FRAME_CNT_EN
    check("frame_cnt", int'(frame_cnt), g.fc);
`endif
  endtask
  initial begin
    logic [5:0] pat;
    pat = 6'b100101;
    repeat (3) step(1'b1, 1'b1);
    repeat (2 * HT * VT + 5) step(1'b0, 1'b1);
    for (int i = 0; i < 60; i++) step(1'b0, pat[5 - (i % 6)]);
    repeat (200) step(1'b0, $urandom_range(0, 2) != 0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    repeat (HT * VT + 3) step(1'b0, 1'b1);
    repeat (37) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
`ifdef VGA_TIMING_FRAME_CNT_EN
    repeat (257 * HT * VT + 2) step(1'b0, 1'b1);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator that supersedes the fixed 640x480 driver. It counts pixel and line positions under a pixel-enable strobe from the system clock, and produces registered, zero-skew sync, blanking, coordinate and line/frame-start outputs. It sits between the pixel-clock-enable divider and the pixel renderers, such as the character generator and shape drawers. Timing, counter width and sync polarities are set per instance.

## Interface
- H_AV, 640: horizontal active pixels
- H_FP, 16: horizontal front porch (pixels)
- H_SP, 96: horizontal sync width (pixels)
- H_BP, 48: horizontal back porch (pixels)
- V_AV, 480: vertical active lines
- V_FP, 11: vertical front porch (lines)
- V_SP, 2: vertical sync width (lines)
- V_BP, 32: vertical back porch (lines)
- H_POL, 0: hSync asserted level (0 = active-low)
- V_POL, 0: vSync asserted level (0 = active-low)
- CW, 11: coordinate counter width; H_TOTAL = H_AV+H_FP+H_SP+H_BP and V_TOTAL likewise must be ≤ 2^CW
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- pix_en  in  1  pixel strobe; counters advance only on clk edges with pix_en=1
- hSync  out  1  horizontal sync, polarity per H_POL
- vSync  out  1  vertical sync, polarity per V_POL
- x  out  CW  current column, 0..H_TOTAL-1
- y  out  CW  current line, 0..V_TOTAL-1
- valid  out  1  high iff x < H_AV and y < V_AV
- line_start  out  1  one-clk pulse on entry to x=0
- frame_start  out  1  one-clk pulse on entry to (0,0)

## Operation
- Position (x,y) is a register pair. On each advance (clk edge with pix_en=1 and reset=0):
  - If x == H_TOTAL-1: x←0. Then, if y == V_TOTAL-1, y←0; otherwise y←y+1.
  - Otherwise: x←x+1.
- Wrap is exact at H_TOTAL-1 and V_TOTAL-1. No extra count beyond the total.
- hSync, vSync and valid are registered. Each is computed from the next position on the same edge that loads x/y, so all outputs describe the same pixel.
  - hSync asserted iff H_AV+H_FP ≤ x < H_AV+H_FP+H_SP.
  - vSync asserted iff V_AV+V_FP ≤ y < V_AV+V_FP+V_SP. vSync changes on the same edge as y.
- line_start is 1 for exactly the clk cycle after an advance into x=0. It is 0 on every other cycle, including cycles where pix_en=0.
- frame_start is the same, but for an advance into (0,0).
- When pix_en=0, x, y, hSync, vSync and valid hold their values.
- Reset state parks the position at the last blanking pixel: x=H_TOTAL-1, y=V_TOTAL-1, valid=0, hSync=~H_POL, vSync=~V_POL, line_start=0, frame_start=0.
  - Therefore the first advance after reset enters (0,0) with both pulses.
  - H_BP>0 and V_BP>0 are required for the parked state to lie outside sync.
- Reset mid-frame immediately returns to the parked state on the next edge, regardless of pix_en.

## Timing
- Latency: 0 between x/y and the sync/valid outputs. All are registered on the same edge.
- Outputs are glitch-free, and all flops are in the clk domain.
- With pix_en held at 1, one frame is H_TOTAL·V_TOTAL clks. The defaults give 800×525 = 420000.
- pix_en may have any duty cycle, for example the 5/8 accumulator strobe. The pulses stay one clk wide.
- Simultaneous reset and pix_en: reset wins.

## Configuration
- VGA_TIMING_FRAME_CNT_EN defined:
  - Adds output port frame_cnt [7:0].
  - frame_cnt is reset to 0.
  - It increments on the same edge that asserts frame_start and wraps from 255 to 0.
  - It is used for blink and animation effects.
- Undefined: the port and register are absent. All other behaviour is identical.

## Test plan
- Default params, pix_en=1: release reset. On the first edge, x=0, y=0, valid=1, line_start=1, frame_start=1, hSync=1, vSync=1. On the next edge, both pulses are 0.
- Line sweep: line_start repeats every 800 clks. hSync=0 exactly for x=656..751 (96 clks). valid drops at x=640.
- Frame sweep: frame_start repeats every 420000 clks. vSync=0 exactly for y=491..492 (1600 clks). y wraps 524→0 when x wraps 799→0.
- pix_en pattern 1,0,1,0,0,1…: x/y advance only on strobe edges. Outputs hold otherwise. line_start stays high for one clk only.
- Reset asserted at (300,200): next edge gives x=799, y=524, valid=0, hSync=1, vSync=1. The first advance after reset gives (0,0) with frame_start=1.
- H_POL=1, V_POL=1, macro defined: hSync=1 for x=656..751. frame_cnt counts 0→255→0 across 256 frames.
